// File: rtl/fsm_step_controller.sv
// Step sequencer for the pattern detector: manual or tick-paced steps,
// one-cycle step_en with a held a_out sample, and a detection counter.
// Ports: clk, reset (sync, active-high), step_req, run_tog, tick, a_in, det
//        -> step_en, a_out, mode[1:0], det_count[CNT_WIDTH-1:0], det_pulse
module fsm_step_controller #(
    parameter int AUTO_PERIOD = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_req,
    input  logic                 run_tog,
    input  logic                 tick,
    input  logic                 a_in,
    input  logic                 det,
    output logic                 step_en,
    output logic                 a_out,
    output logic [1:0]           mode,
    output logic [CNT_WIDTH-1:0] det_count,
    output logic                 det_pulse
);

    localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [PW-1:0] LAST = PW'(AUTO_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        ISSUE = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t               state, state_n;
    logic                 run_flag, run_flag_n;
    logic                 pending, pending_n;
    logic [PW-1:0]        cnt, cnt_n;
    logic                 a_out_n;
    logic [CNT_WIDTH-1:0] det_count_n;
    logic                 det_pulse_n;

    // While a step is in flight, run_tog and step_req are folded into
    // the mode flag and the 1-deep pending slot; run_tog wins over step_req.
    logic flag_eff;
    logic pend_eff;
    assign flag_eff = run_tog ? ~run_flag : run_flag;
    assign pend_eff = ~run_tog & (pending | (step_req & ~run_flag));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PAUSE;
            run_flag  <= 1'b0;
            pending   <= 1'b0;
            cnt       <= '0;
            a_out     <= 1'b0;
            det_count <= '0;
            det_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            run_flag  <= run_flag_n;
            pending   <= pending_n;
            cnt       <= cnt_n;
            a_out     <= a_out_n;
            det_count <= det_count_n;
            det_pulse <= det_pulse_n;
        end
    end

    always_comb begin
        state_n     = state;
        run_flag_n  = run_flag;
        pending_n   = pending;
        cnt_n       = cnt;
        a_out_n     = a_out;
        det_count_n = det_count;
        det_pulse_n = 1'b0;
        unique case (state)
            PAUSE: begin
                if (run_tog) begin
                    state_n    = RUN;
                    run_flag_n = 1'b1;
                    cnt_n      = '0;
                end else if (step_req) begin
                    a_out_n = a_in;
                    state_n = ISSUE;
                end
            end
            RUN: begin
                if (run_tog) begin
                    state_n    = PAUSE;
                    run_flag_n = 1'b0;
                    cnt_n      = '0;
                end else if (tick) begin
                    if (cnt == LAST) begin
                        a_out_n = a_in;
                        cnt_n   = '0;
                        state_n = ISSUE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_n    = CHECK;
                run_flag_n = flag_eff;
                pending_n  = pend_eff;
                if (run_tog) cnt_n = '0;
            end
            CHECK: begin
                run_flag_n = flag_eff;
                pending_n  = 1'b0;
                if (run_tog) cnt_n = '0;
                if (det) begin
                    det_pulse_n = 1'b1;
                    if (det_count != CNT_MAX)
                        det_count_n = det_count + 1'b1;
                end
                if (pend_eff && !flag_eff) begin
                    a_out_n = a_in;
                    state_n = ISSUE;
                end else begin
                    state_n = flag_eff ? RUN : PAUSE;
                end
            end
            default: state_n = PAUSE;
        endcase
    end

    assign step_en = (state == ISSUE);
    assign mode    = state;

endmodule

// File: tb/tb_fsm_step_controller.sv
// Directed bench for fsm_step_controller with a step_en scoreboard.
// Ports: none (drives clk/reset and all stimulus internally).
module tb_fsm_step_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_req = 1'b0;
    logic       run_tog = 1'b0;
    logic       tick = 1'b0;
    logic       a_in = 1'b0;
    logic       det;
    logic       step_en, a_out, det_pulse;
    logic [1:0] mode;
    logic [7:0] det_count;
    logic       step_en2, a_out2, det_pulse2;
    logic [1:0] mode2;
    logic [1:0] det_count2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int   c;
        logic a;
    } exp_t;
    exp_t q[$];

    // Detector stub: y=1 when the last two stepped samples were both 1.
    logic prev;
    always @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
            det  <= 1'b0;
        end else if (step_en) begin
            prev <= a_out;
            det  <= prev & a_out;
        end
    end

    always #5 clk = ~clk;

    fsm_step_controller #(.AUTO_PERIOD(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .step_req(step_req),
        .run_tog(run_tog), .tick(tick), .a_in(a_in), .det(det),
        .step_en(step_en), .a_out(a_out), .mode(mode),
        .det_count(det_count), .det_pulse(det_pulse)
    );

    fsm_step_controller #(.AUTO_PERIOD(4), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .step_req(step_req),
        .run_tog(run_tog), .tick(tick), .a_in(a_in), .det(det),
        .step_en(step_en2), .a_out(a_out2), .mode(mode2),
        .det_count(det_count2), .det_pulse(det_pulse2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cyc %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic a);
        exp_t e;
        e.c = cyc + 1;
        e.a = a;
        q.push_back(e);
    endtask

    // Advance one cycle, then compare step_en against the scoreboard.
    task automatic cyc1();
        logic exp_se;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (q.size() > 0 && q[0].c < cyc) begin
            chk("missed_step_cycle", 32'(cyc), 32'(q[0].c));
            void'(q.pop_front());
        end
        exp_se = (q.size() > 0 && q[0].c == cyc);
        chk("step_en", {31'b0, step_en}, {31'b0, exp_se});
        chk("step_en2", {31'b0, step_en2}, {31'b0, exp_se});
        if (exp_se) begin
            chk("a_out_at_issue", {31'b0, a_out}, {31'b0, q[0].a});
            chk("a_out2_at_issue", {31'b0, a_out2}, {31'b0, q[0].a});
            void'(q.pop_front());
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc1();
    endtask

    task automatic manual_step(input logic a, input int ecnt,
                               input int ecnt2, input logic epulse);
        a_in = a;
        step_req = 1'b1;
        push(a);
        cyc1();
        step_req = 1'b0;
        chk("mode_issue", 32'(mode), 32'd2);
        cyc1();
        chk("mode_check", 32'(mode), 32'd3);
        chk("pulse_in_check", {31'b0, det_pulse}, 32'd0);
        cyc1();
        chk("mode_back", 32'(mode), 32'd0);
        chk("mode2_back", 32'(mode2), 32'd0);
        chk("a_out_held", {31'b0, a_out}, {31'b0, a});
        chk("det_pulse", {31'b0, det_pulse}, {31'b0, epulse});
        chk("det_pulse2", {31'b0, det_pulse2}, {31'b0, epulse});
        chk("det_count", 32'(det_count), 32'(ecnt));
        chk("det_count2", 32'(det_count2), 32'(ecnt2));
        cyc1();
        chk("pulse_one_cycle", {31'b0, det_pulse}, 32'd0);
    endtask

    initial begin
        // 1: reset state, then one manual step.
        cycles(2);
        reset = 1'b0;
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_a_out", {31'b0, a_out}, 32'd0);
        chk("rst_count", 32'(det_count), 32'd0);
        chk("rst_pulse", {31'b0, det_pulse}, 32'd0);
        cycles(2);
        manual_step(1'b1, 0, 0, 1'b0);

        // 2: a = 0,1,1 -> one detection on the third step.
        manual_step(1'b0, 0, 0, 1'b0);
        manual_step(1'b1, 0, 0, 1'b0);
        manual_step(1'b1, 1, 1, 1'b1);

        // 3: auto-run, tick every cycle -> step every 6 cycles.
        a_in = 1'b0;
        run_tog = 1'b1;
        cyc1();
        run_tog = 1'b0;
        chk("mode_run", 32'(mode), 32'd1);
        tick = 1'b1;
        q.push_back('{cyc + 4, 1'b0});
        q.push_back('{cyc + 10, 1'b0});
        q.push_back('{cyc + 16, 1'b0});
        cycles(18);
        chk("mode_still_run", 32'(mode), 32'd1);
        run_tog = 1'b1;
        cyc1();
        run_tog = 1'b0;
        chk("mode_paused", 32'(mode), 32'd0);
        cycles(12);
        chk("no_auto_in_pause", 32'(mode), 32'd0);
        tick = 1'b0;
        chk("auto_queue_drained", 32'(q.size()), 32'd0);

        // 4: five detections; 2-bit counter saturates at 3.
        manual_step(1'b1, 1, 1, 1'b0);
        manual_step(1'b1, 2, 2, 1'b1);
        manual_step(1'b1, 3, 3, 1'b1);
        manual_step(1'b1, 4, 3, 1'b1);
        manual_step(1'b1, 5, 3, 1'b1);
        manual_step(1'b1, 6, 3, 1'b1);

        // 5a: step_req + run_tog together in PAUSE -> RUN, no step.
        a_in = 1'b0;
        step_req = 1'b1;
        run_tog = 1'b1;
        cyc1();
        step_req = 1'b0;
        run_tog = 1'b0;
        chk("mode_tog_wins", 32'(mode), 32'd1);
        cycles(3);
        run_tog = 1'b1;
        cyc1();
        run_tog = 1'b0;
        chk("mode_back_pause", 32'(mode), 32'd0);

        // 5b: req at N and N+2 -> step_en at N+1 and N+3.
        step_req = 1'b1;
        push(1'b0);
        cyc1();
        step_req = 1'b0;
        cyc1();
        chk("mode_check_5b", 32'(mode), 32'd3);
        step_req = 1'b1;
        push(1'b0);
        cyc1();
        step_req = 1'b0;
        cycles(5);
        chk("mode_idle_5b", 32'(mode), 32'd0);

        // 5c: req at N, N+1, N+2 -> still only N+1 and N+3.
        step_req = 1'b1;
        push(1'b0);
        cyc1();
        q.push_back('{cyc + 2, 1'b0});
        cycles(2);
        step_req = 1'b0;
        cycles(5);
        chk("mode_idle_5c", 32'(mode), 32'd0);
        chk("queue_drained_5", 32'(q.size()), 32'd0);

        // 6: reset during ISSUE aborts the step.
        a_in = 1'b1;
        step_req = 1'b1;
        push(1'b1);
        cyc1();
        step_req = 1'b0;
        chk("mode_issue_6", 32'(mode), 32'd2);
        reset = 1'b1;
        cyc1();
        reset = 1'b0;
        chk("abort_step_en", {31'b0, step_en}, 32'd0);
        chk("abort_mode", 32'(mode), 32'd0);
        chk("abort_count", 32'(det_count), 32'd0);
        chk("abort_a_out", {31'b0, a_out}, 32'd0);
        cycles(2);
        manual_step(1'b1, 0, 0, 1'b0);
        manual_step(1'b1, 1, 1, 1'b1);

        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
